// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported synchronous memory.
// Port B may lock ownership across back-to-back transactions.
module mem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 4096,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state, state_n;
  logic                owner_b, owner_b_n;
  logic                we_q, we_q_n;
  logic                lock_q, lock_q_n;
  logic                err_q, err_q_n;
  logic                rr_last_b, rr_last_b_n;
  logic                lock_own, lock_own_n;
  logic                a_gnt_n, b_gnt_n, a_done_n, b_done_n, a_err_n, b_err_n;
  logic                a_rsel, b_rsel, a_rsel_n, b_rsel_n;
  logic                mem_en_n, mem_we_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic [CNT_W-1:0]    a_count_n, b_count_n;

  logic                pick_b;
  logic                pick_we;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic                pick_in_range;

  // Lock wins outright; otherwise a lone requester wins; a tie goes to the port not served last.
  assign pick_b        = (lock_own && b_req) || (b_req && !a_req) ||
                         (a_req && b_req && !rr_last_b);
  assign pick_we       = pick_b ? b_we    : a_we;
  assign pick_addr     = pick_b ? b_addr  : a_addr;
  assign pick_wdata    = pick_b ? b_wdata : a_wdata;
  assign pick_in_range = {1'b0, pick_addr} < DEPTH;

  always_comb begin
    state_n     = IDLE;
    owner_b_n   = owner_b;
    we_q_n      = we_q;
    lock_q_n    = lock_q;
    err_q_n     = err_q;
    rr_last_b_n = rr_last_b;
    lock_own_n  = lock_own;
    a_gnt_n     = 1'b0;
    b_gnt_n     = 1'b0;
    a_done_n    = 1'b0;
    b_done_n    = 1'b0;
    a_err_n     = 1'b0;
    b_err_n     = 1'b0;
    a_rsel_n    = 1'b0;
    b_rsel_n    = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    a_count_n   = a_count;
    b_count_n   = b_count;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          state_n     = ACCESS;
          owner_b_n   = pick_b;
          we_q_n      = pick_we;
          lock_q_n    = pick_b && b_lock;
          err_q_n     = !pick_in_range;
          a_gnt_n     = !pick_b;
          b_gnt_n     = pick_b;
          mem_en_n    = pick_in_range;
          mem_we_n    = pick_in_range && pick_we;
          mem_addr_n  = pick_addr;
          mem_wdata_n = pick_wdata;
          if (!pick_b) lock_own_n = 1'b0;
        end else begin
          state_n    = IDLE;
          lock_own_n = 1'b0;
        end
      end
      ACCESS: begin
        state_n     = RESP;
        a_done_n    = !owner_b;
        b_done_n    = owner_b;
        a_err_n     = !owner_b && err_q;
        b_err_n     = owner_b && err_q;
        a_rsel_n    = !owner_b && !we_q && !err_q;
        b_rsel_n    = owner_b && !we_q && !err_q;
        rr_last_b_n = owner_b;
        lock_own_n  = owner_b && lock_q;
        if (owner_b) begin
          if (b_count != '1) b_count_n = b_count + CNT_ONE;
        end else begin
          if (a_count != '1) a_count_n = a_count + CNT_ONE;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_b   <= 1'b0;
      we_q      <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      rr_last_b <= 1'b1;
      lock_own  <= 1'b0;
      a_gnt     <= 1'b0;
      b_gnt     <= 1'b0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      a_rsel    <= 1'b0;
      b_rsel    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_count   <= '0;
      b_count   <= '0;
    end else begin
      state     <= state_n;
      owner_b   <= owner_b_n;
      we_q      <= we_q_n;
      lock_q    <= lock_q_n;
      err_q     <= err_q_n;
      rr_last_b <= rr_last_b_n;
      lock_own  <= lock_own_n;
      a_gnt     <= a_gnt_n;
      b_gnt     <= b_gnt_n;
      a_done    <= a_done_n;
      b_done    <= b_done_n;
      a_err     <= a_err_n;
      b_err     <= b_err_n;
      a_rsel    <= a_rsel_n;
      b_rsel    <= b_rsel_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      a_count   <= a_count_n;
      b_count   <= b_count_n;
    end
  end

  // Memory data only exists in the RESP cycle, so read data is a registered-select gate of it.
  assign a_rdata = a_rsel ? mem_rdata : '0;
  assign b_rdata = b_rsel ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency memory model.
// Uses MEM_DEPTH=7 for range checks and CNT_W=2 so counter saturation is reachable.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk, rst_n;
  logic          a_req, a_we, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] a_count, b_count;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(7), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .a_count(a_count), .b_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:4095];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int cyc = 0;
  int g_port[$];
  int g_cyc[$];
  int d_cyc[$];
  int mem_en_n = 0, b_gnt_n = 0, b_done_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_gnt) begin g_port.push_back(0); g_cyc.push_back(cyc); end
    if (b_gnt) begin g_port.push_back(1); g_cyc.push_back(cyc); end
    if (a_done || b_done) d_cyc.push_back(cyc);
    if (mem_en) mem_en_n++;
    if (b_gnt)  b_gnt_n++;
    if (b_done) b_done_n++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic preload(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    pre_en = 1; pre_addr = ad; pre_data = d;
    tick();
    pre_en = 0;
  endtask

  int base, dbase, snap, snap2;

  initial begin
    pre_en = 0; pre_addr = '0; pre_data = '0;
    rst_n = 0;
    idle_inputs();
    #1;
    preload(12'd2, 32'h1000_0000);
    preload(12'd6, 32'h0000_0066);
    tick();
    chk("rst_a_gnt", 32'(a_gnt), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_b_count", 32'(b_count), 0);
    chk("rst_a_rdata", a_rdata, 0);
    rst_n = 1;

    // single A read
    snap = b_gnt_n;
    a_req = 1; a_we = 0; a_addr = 12'd2;
    tick();
    chk("t1_a_gnt", 32'(a_gnt), 1);
    chk("t1_mem_en", 32'(mem_en), 1);
    chk("t1_mem_addr", 32'(mem_addr), 2);
    tick();
    chk("t1_a_done", 32'(a_done), 1);
    chk("t1_a_rdata", a_rdata, 32'h1000_0000);
    chk("t1_a_err", 32'(a_err), 0);
    chk("t1_a_count", 32'(a_count), 1);
    tick();
    a_req = 0;
    tick(); tick();
    chk("t1_no_b_gnt", 32'(b_gnt_n - snap), 0);

    // B write then A read-back
    do_reset();
    b_req = 1; b_we = 1; b_addr = 12'd3; b_wdata = 32'h9000_0000;
    tick();
    chk("t2_b_gnt", 32'(b_gnt), 1);
    chk("t2_mem_we", 32'(mem_we), 1);
    chk("t2_mem_wdata", mem_wdata, 32'h9000_0000);
    tick();
    chk("t2_b_done", 32'(b_done), 1);
    chk("t2_b_rdata", b_rdata, 0);
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 12'd3;
    tick(); tick(); tick();
    chk("t2_a_done", 32'(a_done), 1);
    chk("t2_a_rdata", a_rdata, 32'h9000_0000);
    chk("t2_a_count", 32'(a_count), 1);
    chk("t2_b_count", 32'(b_count), 1);
    tick();
    a_req = 0;

    // both held: A,B,A,B every 3 cycles
    do_reset();
    base = g_port.size(); dbase = d_cyc.size();
    a_req = 1; a_we = 0; a_addr = 12'd2;
    b_req = 1; b_we = 0; b_addr = 12'd3;
    repeat (11) tick();
    a_req = 0; b_req = 0;
    repeat (3) tick();
    chk("t3_n_gnt", 32'(g_port.size() - base), 4);
    chk("t3_n_done", 32'(d_cyc.size() - dbase), 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < g_port.size())
        chk($sformatf("t3_order%0d", i), 32'(g_port[base+i]), 32'(i % 2));
      if (i > 0 && dbase + i < d_cyc.size())
        chk($sformatf("t3_dgap%0d", i), 32'(d_cyc[dbase+i] - d_cyc[dbase+i-1]), 3);
    end
    if (dbase < d_cyc.size() && base < g_cyc.size())
      chk("t3_gnt2done", 32'(d_cyc[dbase] - g_cyc[base]), 1);
    chk("t3_a_count", 32'(a_count), 2);
    chk("t3_b_count", 32'(b_count), 2);

    // B lock: B,B,B then A
    do_reset();
    base = g_port.size();
    b_req = 1; b_lock = 1; b_we = 0; b_addr = 12'd3;
    tick();
    a_req = 1; a_we = 0; a_addr = 12'd2;
    repeat (3) tick();
    b_lock = 0;
    repeat (7) tick();
    a_req = 0; b_req = 0;
    repeat (3) tick();
    chk("t4_n_gnt", 32'(g_port.size() - base), 4);
    for (int i = 0; i < 4; i++)
      if (base + i < g_port.size())
        chk($sformatf("t4_order%0d", i), 32'(g_port[base+i]), (i < 3) ? 1 : 0);
    chk("t4_b_count", 32'(b_count), 3);
    chk("t4_a_count", 32'(a_count), 1);

    // out-of-range write and read, in-range edge, counter saturation
    do_reset();
    snap = mem_en_n;
    a_req = 1; a_we = 1; a_addr = 12'hFFF; a_wdata = 32'hDEAD_BEEF;
    tick();
    chk("t5_a_gnt", 32'(a_gnt), 1);
    chk("t5_mem_en", 32'(mem_en), 0);
    tick();
    chk("t5_a_done", 32'(a_done), 1);
    chk("t5_a_err", 32'(a_err), 1);
    chk("t5_a_rdata", a_rdata, 0);
    chk("t5_a_count", 32'(a_count), 1);
    tick();
    a_we = 0; a_addr = 12'd7;
    tick(); tick();
    chk("t5_err7", 32'(a_err), 1);
    chk("t5_rdata7", a_rdata, 0);
    chk("t5_no_mem_en", 32'(mem_en_n - snap), 0);
    tick();
    a_addr = 12'd6;
    tick(); tick();
    chk("t5_err6", 32'(a_err), 0);
    chk("t5_rdata6", a_rdata, 32'h0000_0066);
    chk("t5_count3", 32'(a_count), 3);
    tick();
    tick(); tick();
    chk("t5_sat", 32'(a_count), 3);
    tick();
    a_req = 0;

    // reset during a B access
    do_reset();
    snap2 = b_done_n;
    b_req = 1; b_we = 0; b_addr = 12'd3;
    tick();
    chk("t6_b_gnt", 32'(b_gnt), 1);
    rst_n = 0;
    #1;
    chk("t6_b_gnt_rst", 32'(b_gnt), 0);
    chk("t6_mem_en_rst", 32'(mem_en), 0);
    chk("t6_mem_addr_rst", 32'(mem_addr), 0);
    a_req = 1; a_we = 0; a_addr = 12'd2;
    tick();
    rst_n = 1;
    tick();
    chk("t6_no_b_done", 32'(b_done_n - snap2), 0);
    chk("t6_a_first", 32'(a_gnt), 1);
    chk("t6_b_not", 32'(b_gnt), 0);
    tick(); tick();
    a_req = 0; b_req = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 32-bit instruction/data memory between two requesters.
  - Port A: the processor core (fetch, load, store writeback).
  - Port B: a host loader/debug port that writes program images and reads back results.
- One memory transaction at a time, round-robin arbitration, optional burst lock for port B.
- Sits between the requesters and the synchronous memory array.

Parameters:
- ADDR_W, 12, width of requester and memory address (matches the 12-bit instruction address fields).
- DATA_W, 32, data word width.
- MEM_DEPTH, 4096, number of valid words; addresses >= MEM_DEPTH are rejected.
- CNT_W, 16, width of the per-port transaction counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A request, level; held with a_we/a_addr/a_wdata stable until a_done.
- a_we  input  1  port A write enable (1=write, 0=read).
- a_addr  input  ADDR_W  port A word address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  one-cycle pulse when port A's access is issued to memory.
- a_done  output  1  one-cycle pulse when port A's transaction completes.
- a_rdata  output  DATA_W  read data, valid with a_done.
- a_err  output  1  with a_done: address out of range.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata, b_err: same as port A, for port B.
- b_lock  input  1  with b_req: keep ownership for port B after its transaction.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en (1-cycle latency).
- a_count, b_count  output  CNT_W  completed transactions per port, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All gnt/done/err/mem_en/mem_we = 0; rdata, mem_addr, mem_wdata = 0.
  - Counters = 0; rr_last = B, so A wins the first tie; lock_own = 0.
- Reset mid-transaction aborts it: no done pulse, and a pending write may or may not have reached memory.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise pick the winner, latch its we/addr/wdata, record owner, go to ACCESS.
- Winner selection:
  - lock_own=1 and b_req=1 -> B.
  - Else only one request -> that one.
  - Both requesting -> the port != rr_last.
- ACCESS (one cycle):
  - owner gnt=1.
  - Address in range: mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latch.
  - Address >= MEM_DEPTH: mem_en=0, mark error.
  - Then go to RESP.
- RESP (one cycle):
  - owner done=1.
  - Read in range: rdata=mem_rdata.
  - Write, or any error: rdata=0.
  - err=error flag.
  - rr_last=owner; lock_own = (owner==B && b_lock); owner counter +1, saturating at all-ones, errors included.
  - Then go to IDLE.
- Latency:
  - Request sampled in IDLE at edge t; gnt during cycle t+1; done during cycle t+2.
  - Next arbitration at edge t+3.
  - Minimum 3 cycles per transaction; back-to-back throughput is one transaction per 3 cycles.
- Requester rules:
  - Deassert req in the cycle after done unless another transaction is wanted.
  - req still high at the next IDLE sample is a new transaction.
  - Changing we/addr/wdata while req is high and before gnt is illegal; the latch takes the value at the IDLE edge.
- b_lock without b_req:
  - Ignored for selection.
  - lock_own is cleared when B is not selected in IDLE.
- Port A requests during a B lock wait; no A starvation bound while b_lock is held.
- Memory writes take effect at the end of ACCESS; a read of the same address in a later transaction returns the new data.

Test Plan:
- Reset then a_req=1, a_we=0, a_addr=2 with mem[2]=32'h10000000:
  - a_gnt in cycle 1, a_done in cycle 2 with a_rdata=32'h10000000, a_err=0.
  - a_count=1; b_gnt never asserted.
- Port B writes 32'h90000000 to addr 3, then port A reads addr 3 -> a_rdata=32'h90000000, b_count=1, a_count=1.
- a_req and b_req asserted together and held for 4 transactions -> grant order A,B,A,B; each done 3 cycles apart.
- b_lock=1 with b_req held and a_req held, 3 B transactions, then b_lock=0:
  - Order B,B,B, then A.
  - Exercises the single-port path: A first goes idle, then A is pending throughout.
- a_addr=12'hFFF with MEM_DEPTH=7, a_we=1 -> mem_en never asserted; a_done with a_err=1, a_rdata=0.
- rst_n pulsed low during ACCESS of a B read -> all outputs 0 immediately; no b_done; the next a_req is granted first.
